// File: rtl/fetch_stage_pkg.sv
// Constants for the fetch stage that are shared with decode and the hazard unit.
// This covers the NOP encoding, the default reset PC, opcodes and an alignment helper.
package fetch_stage_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Control-transfer opcodes; these are resolved downstream and arrive here as redirects.
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus. It carries the instruction-memory port, the hazard/redirect
// inputs and the IF/ID outputs. The master side is the fetch stage.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       if_id_instr;
    logic [ADDR_W-1:0] if_id_pc4;
    logic              if_id_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect,
        output redirect_pc,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A bubble insert takes priority over a load, and a load
// enable of 0 holds all fields. The register clears asynchronously to a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic [31:0]       instr_d,
    input  logic [ADDR_W-1:0] pc4_d,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4,
    output logic              valid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr <= NOP;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. It owns the PC, addresses instruction memory and loads IF/ID.
// The priority order is redirect, then stall, then normal fetch. Perf counters saturate.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset,
    fetch_stage_if.master     bus,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_target;
    logic              fetch_en;

    assign pc_plus4        = pc_reg + ADDR_W'(4);
    assign redirect_target = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign fetch_en        = !bus.redirect && !bus.stall;
    assign bus.imem_addr   = {pc_reg[ADDR_W-1:2], 2'b00};

    // redirect_pc is only looked at under redirect, so an X there cannot leak into pc
    always_comb begin
        pc_next = pc_reg;
        if (bus.redirect) begin
            pc_next = redirect_target;
        end else if (!bus.stall) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
            bubble_cnt   <= '0;
        end else begin
            pc_reg <= pc_next;
            if (bus.redirect && is_misaligned(bus.redirect_pc[1:0])) begin
                misalign_err <= 1'b1;
            end
            if (fetch_en && (fetch_cnt != {CNT_W{1'b1}})) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (bus.redirect && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    // The wrong-path instruction is squashed by the bubble even when stall is also high
    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (!bus.stall),
        .bubble  (bus.redirect),
        .instr_d (bus.imem_rdata),
        .pc4_d   (pc_plus4),
        .instr   (bus.if_id_instr),
        .pc4     (bus.if_id_pc4),
        .valid   (bus.if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A second instance with 3-bit counters
// shares the same stimulus so that counter saturation can be reached quickly.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall_r;
    logic        redirect_r;
    logic [31:0] redirect_pc_r;
    logic [31:0] mem [0:63];

    logic        misalign_err, sat_misalign_err;
    logic [15:0] fetch_cnt, bubble_cnt;
    logic [2:0]  sat_fetch_cnt, sat_bubble_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage_if #(.ADDR_W(32)) bus ();
    fetch_stage_if #(.ADDR_W(32)) sat_bus ();

    assign bus.imem_rdata      = mem[bus.imem_addr[7:2]];
    assign bus.stall           = stall_r;
    assign bus.redirect        = redirect_r;
    assign bus.redirect_pc     = redirect_pc_r;
    assign sat_bus.imem_rdata  = mem[sat_bus.imem_addr[7:2]];
    assign sat_bus.stall       = stall_r;
    assign sat_bus.redirect    = redirect_r;
    assign sat_bus.redirect_pc = redirect_pc_r;

    fetch_stage #(.ADDR_W(32), .CNT_W(16), .RESET_PC(32'h0)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.master),
        .misalign_err (misalign_err),
        .fetch_cnt    (fetch_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    fetch_stage #(.ADDR_W(32), .CNT_W(3), .RESET_PC(32'h0)) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .bus          (sat_bus.master),
        .misalign_err (sat_misalign_err),
        .fetch_cnt    (sat_fetch_cnt),
        .bubble_cnt   (sat_bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        $display("t=%0t %s addr=%08h instr=%08h pc4=%08h valid=%0b fetch=%0d bubble=%0d",
                 $time, tag, bus.imem_addr, bus.if_id_instr, bus.if_id_pc4,
                 bus.if_id_valid, fetch_cnt, bubble_cnt);
        check({tag, ".addr"},  bus.imem_addr, addr);
        check({tag, ".instr"}, bus.if_id_instr, instr);
        check({tag, ".pc4"},   bus.if_id_pc4, pc4);
        check({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[2]  = 32'h33;
        mem[16] = 32'hAA;
        mem[17] = 32'hBB;
        mem[18] = 32'hCC;
        mem[63] = 32'hFC;

        reset = 1'b0; stall_r = 1'b0; redirect_r = 1'b0; redirect_pc_r = 32'h0;
        tick(); tick();
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.fetch_cnt",  {16'd0, fetch_cnt}, 32'd0);
        check("reset.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        check("reset.misalign",   {31'd0, misalign_err}, 32'd0);

        // Release the reset, then fetch sequentially
        reset = 1'b1;
        tick(); check_ifid("seq0", 32'h4, 32'h11, 32'h4, 1'b1);
        tick(); check_ifid("seq1", 32'h8, 32'h22, 32'h8, 1'b1);
        check("seq1.fetch_cnt", {16'd0, fetch_cnt}, 32'd2);

        // Stall for two edges at pc=8
        stall_r = 1'b1;
        tick(); check_ifid("stall0", 32'h8, 32'h22, 32'h8, 1'b1);
        tick(); check_ifid("stall1", 32'h8, 32'h22, 32'h8, 1'b1);
        check("stall.fetch_cnt",  {16'd0, fetch_cnt}, 32'd2);
        check("stall.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        stall_r = 1'b0;
        tick(); check_ifid("resume", 32'hC, 32'h33, 32'hC, 1'b1);
        check("resume.fetch_cnt", {16'd0, fetch_cnt}, 32'd3);

        // Redirect to 0x40
        redirect_r = 1'b1; redirect_pc_r = 32'h40;
        tick(); check_ifid("redir", 32'h40, 32'h0, 32'h0, 1'b0);
        check("redir.bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        redirect_r = 1'b0; redirect_pc_r = 32'hxxxx_xxxx;
        tick(); check_ifid("redir_next", 32'h44, 32'hAA, 32'h44, 1'b1);
        check("redir_next.fetch_cnt", {16'd0, fetch_cnt}, 32'd4);

        // Redirect with a simultaneous stall: the redirect wins
        redirect_r = 1'b1; stall_r = 1'b1; redirect_pc_r = 32'h10;
        tick(); check_ifid("redir_stall", 32'h10, 32'h0, 32'h0, 1'b0);
        check("redir_stall.bubble_cnt", {16'd0, bubble_cnt}, 32'd2);
        redirect_r = 1'b0; stall_r = 1'b0;
        tick(); check_ifid("redir_stall_next", 32'h14, 32'h1004, 32'h14, 1'b1);

        // Misaligned redirect target
        redirect_r = 1'b1; redirect_pc_r = 32'h42;
        tick(); check_ifid("misalign", 32'h40, 32'h0, 32'h0, 1'b0);
        check("misalign.flag", {31'd0, misalign_err}, 32'd1);
        redirect_r = 1'b0;
        tick(); check_ifid("misalign_next", 32'h44, 32'hAA, 32'h44, 1'b1);
        check("misalign.sticky", {31'd0, misalign_err}, 32'd1);
        tick(); check_ifid("seq_bb", 32'h48, 32'hBB, 32'h48, 1'b1);
        tick(); check_ifid("seq_cc", 32'h4C, 32'hCC, 32'h4C, 1'b1);
        check("sat.fetch_main", {16'd0, fetch_cnt}, 32'd8);
        check("sat.fetch_sat",  {29'd0, sat_fetch_cnt}, 32'd7);
        check("sat.bubble_sat", {29'd0, sat_bubble_cnt}, 32'd3);
        check("misalign.sticky2", {31'd0, misalign_err}, 32'd1);

        // Move to pc=0x20, then assert reset in the middle of a cycle
        redirect_r = 1'b1; redirect_pc_r = 32'h20;
        tick(); check("pre_reset.addr", bus.imem_addr, 32'h20);
        redirect_r = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("async_reset.fetch_cnt",  {16'd0, fetch_cnt}, 32'd0);
        check("async_reset.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        check("async_reset.misalign",   {31'd0, misalign_err}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // PC wraps modulo 2^32 without raising a flag
        redirect_r = 1'b1; redirect_pc_r = 32'hFFFF_FFFC;
        tick(); check("wrap_pre.addr", bus.imem_addr, 32'hFFFF_FFFC);
        redirect_r = 1'b0;
        tick(); check_ifid("wrap", 32'h0, 32'hFC, 32'h0, 1'b1);
        check("wrap.misalign", {31'd0, misalign_err}, 32'd0);
        check("wrap.fetch_cnt", {16'd0, fetch_cnt}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
